// File: rtl/adder_cg_sched_if.sv
// Request/response handshake bundle between the two requesters, the response sink
// and the adder scheduler.
interface adder_cg_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_cin;

  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_cin;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_sum;
  logic        resp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_sum, resp_cout
  );
endinterface

// File: rtl/adder_cg_sched.sv
// Round-robin scheduler for the split 16-bit adder: one op in flight, upper half
// clocked only when its result can be non-zero, and a count of gated ops.
module adder_cg_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  adder_cg_sched_if.slave  bus,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cin,
  input  logic [15:0]      add_sum,
  input  logic             add_cout,
  output logic             add_cg,
  input  logic             cg_force,
  output logic [CNT_W-1:0] gated_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             ready0_q;
  logic             ready1_q;
  logic [15:0]      op_a_q;
  logic [15:0]      op_b_q;
  logic             op_cin_q;
  logic             op_id_q;
  logic             cg_req_q;
  logic             add_cg_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [15:0]      resp_sum_q;
  logic             resp_cout_q;
  logic [CNT_W-1:0] gated_cnt_q;
  logic [CNT_W-1:0] gated_cnt_d;

  logic        acc0;
  logic        acc1;
  logic        accept;
  logic        win0;
  logic        win1;
  logic        resp_done;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic        sel_cin;
  logic [8:0]  low_sum;
  logic        need_msb;

  assign acc0      = ready0_q & bus.req0_valid;
  assign acc1      = ready1_q & bus.req1_valid;
  assign accept    = acc0 | acc1;
  assign resp_done = resp_valid_q & bus.resp_ready;

  // Ready is registered from sampled valids; a requester holds valid until accepted,
  // so a grant issued from last cycle's valids is still good.
  assign win0 = bus.req0_valid & (~bus.req1_valid |  last_grant_q);
  assign win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  assign sel_a   = acc1 ? bus.req1_a   : bus.req0_a;
  assign sel_b   = acc1 ? bus.req1_b   : bus.req0_b;
  assign sel_cin = acc1 ? bus.req1_cin : bus.req0_cin;

  // Upper half is needed if either upper operand byte is set or the low byte carries.
  assign low_sum  = {1'b0, sel_a[7:0]} + {1'b0, sel_b[7:0]} + {8'd0, sel_cin};
  assign need_msb = (|sel_a[15:8]) | (|sel_b[15:8]) | low_sum[8];

  assign gated_cnt_d = (&gated_cnt_q) ? gated_cnt_q : gated_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_id_q      <= 1'b0;
      cg_req_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      gated_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            op_cin_q     <= sel_cin;
            op_id_q      <= acc1;
            cg_req_q     <= need_msb | cg_force;
            last_grant_q <= acc1;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            state_q      <= ISSUE;
          end else begin
            ready0_q <= win0;
            ready1_q <= win1;
          end
        end
        ISSUE: begin
          state_q <= CAPT;
        end
        CAPT: begin
          // When gated the upper register is stale; the true upper result is zero.
          resp_sum_q   <= {(cg_req_q ? add_sum[15:8] : 8'h00), add_sum[7:0]};
          resp_cout_q  <= add_cout;
          resp_id_q    <= op_id_q;
          resp_valid_q <= 1'b1;
          if (!cg_req_q) begin
            gated_cnt_q <= gated_cnt_d;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp_valid_q <= 1'b0;
            cg_req_q     <= 1'b0;
            ready0_q     <= win0;
            ready1_q     <= win1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Retimed on the falling edge so the AND-gated upper clock never glitches.
  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      add_cg_q <= 1'b0;
    end else begin
      add_cg_q <= cg_req_q;
    end
  end

  assign bus.req0_ready = ready0_q;
  assign bus.req1_ready = ready1_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_cout  = resp_cout_q;

  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign add_cin   = op_cin_q;
  assign add_cg    = add_cg_q;
  assign gated_cnt = gated_cnt_q;

endmodule

// File: tb/tb_adder_cg_sched.sv
// Bench for adder_cg_sched: models the split adder, drives requesters and checks
// responses, timing and gating against plain-arithmetic expectations.
module tb_adder_cg_sched;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        cg_force = 1'b0;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        add_cg;
  logic [1:0]  gated_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cnt = 0;

  adder_cg_sched_if bus();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Split adder: low half always clocked, upper half only when add_cg is high.
  logic [7:0] lo_q = 8'h00;
  logic [7:0] hi_q = 8'h00;
  logic [8:0] lo_full;
  logic [8:0] hi_full;
  assign lo_full  = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_cin};
  assign hi_full  = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]} + {8'd0, lo_full[8]};
  assign add_sum  = {hi_q, lo_q};
  assign add_cout = hi_full[8];
  always @(posedge clk) begin
    lo_q <= lo_full[7:0];
    if (add_cg) hi_q <= hi_full[7:0];
  end

  adder_cg_sched #(.CNT_W(2)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .add_cg    (add_cg),
    .cg_force  (cg_force),
    .gated_cnt (gated_cnt)
  );

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  // The upper half may be skipped exactly when the full result fits in the low byte.
  function automatic bit ref_gated(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic frc);
    return !frc && (ref_sum(a, b, cin) < 17'd256);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b0;
    cg_force = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    exp_cnt = 0;
  endtask

  // Drives one request, waits for its response, optionally stalls resp_ready.
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int stall, output bit tmo, output int acc_edge, output int rv_edge,
                        output logic [15:0] sum, output logic cout, output logic rid,
                        output logic cg_issue, output logic [1:0] cnt, output bit stable);
    int n;
    tmo = 0; stable = 1; acc_edge = -1; rv_edge = -1;
    sum = '0; cout = 1'b0; rid = 1'b0; cg_issue = 1'b0; cnt = '0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (id == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
    end
    n = 0;
    while (!((id == 1'b0) ? bus.req0_ready : bus.req1_ready) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      tmo = 1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1 cg_issue = add_cg;
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      tmo = 1;
      return;
    end
    rv_edge = cyc; sum = bus.resp_sum; cout = bus.resp_cout; rid = bus.resp_id; cnt = gated_cnt;
    repeat (stall) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_sum !== sum || bus.resp_cout !== cout || bus.resp_id !== rid ||
          bus.req0_ready || bus.req1_ready) stable = 0;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    $display("op id=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d id=%0d cg=%0d cnt=%0d",
             id, a, b, cin, sum, cout, rid, cg_issue, cnt);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_cout} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
                      {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_cout});
    end
    total++; if (bus.resp_sum !== 16'h0) begin bad++; $display("FAIL reset_sum got=%h want=0000", bus.resp_sum); end
    total++; if ({add_a, add_b, add_cin} !== 33'h0) begin
      bad++; $display("FAIL reset_add_ops got=%h/%h/%b want=0", add_a, add_b, add_cin);
    end
    total++; if (add_cg !== 1'b0) begin bad++; $display("FAIL reset_add_cg got=%b want=0", add_cg); end
    total++; if (gated_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", gated_cnt); end
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b0) begin
      bad++; $display("FAIL idle_quiet got=%b want=000", {bus.req0_ready, bus.req1_ready, bus.resp_valid});
    end
  endtask

  task automatic test_full_carry();
    bit tmo, st; int ae, re; logic [15:0] s; logic c, r, g; logic [1:0] k;
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 0, tmo, ae, re, s, c, r, g, k, st);
    total++; if (tmo) begin bad++; $display("FAIL full_carry_timeout got=1 want=0"); end
    total++; if (g !== 1'b1) begin bad++; $display("FAIL full_carry_cg got=%b want=1", g); end
    total++; if (s !== 16'h0100 || c !== 1'b0 || r !== 1'b0) begin
      bad++; $display("FAIL full_carry_resp got=%h/%b/%b want=0100/0/0", s, c, r);
    end
    // cycle 3 begins at the second posedge after the accept edge
    total++; if (re !== ae + 2) begin bad++; $display("FAIL full_carry_latency got=%0d want=%0d", re, ae + 2); end
    total++; if (k !== 2'(exp_cnt)) begin bad++; $display("FAIL full_carry_cnt got=%0d want=%0d", k, exp_cnt); end
  endtask

  task automatic test_gated_stale();
    bit tmo, st; int ae, re; logic [15:0] s; logic c, r, g; logic [1:0] k;
    run_op(1'b1, 16'h1200, 16'h3400, 1'b0, 0, tmo, ae, re, s, c, r, g, k, st);
    total++; if (tmo || s !== 16'h4600 || r !== 1'b1 || g !== 1'b1) begin
      bad++; $display("FAIL stale_setup got=%h id=%b cg=%b tmo=%0d want=4600 id=1 cg=1 tmo=0", s, r, g, tmo);
    end
    run_op(1'b0, 16'h0012, 16'h0034, 1'b1, 0, tmo, ae, re, s, c, r, g, k, st);
    exp_cnt = sat_inc(exp_cnt);
    total++; if (g !== 1'b0) begin bad++; $display("FAIL gated_cg got=%b want=0", g); end
    total++; if (hi_q !== 8'h46) begin bad++; $display("FAIL gated_upper_reg got=%h want=46", hi_q); end
    total++; if (tmo || s !== 16'h0047 || c !== 1'b0 || r !== 1'b0) begin
      bad++; $display("FAIL gated_resp got=%h/%b/%b want=0047/0/0", s, c, r);
    end
    total++; if (k !== 2'(exp_cnt)) begin bad++; $display("FAIL gated_cnt got=%0d want=%0d", k, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int n, h_edge, a1_edge;
    bit ok;
    logic [15:0] s;
    logic r, c;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req0_a = 16'h0F0F; bus.req0_b = 16'h0101; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
    n = 0;
    while (!bus.req0_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_a = 16'h0020; bus.req1_b = 16'h0030; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL bp_resp_timeout got=none want=resp"); end
    s = bus.resp_sum; r = bus.resp_id; c = bus.resp_cout;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_sum !== s || bus.resp_id !== r || bus.resp_cout !== c ||
          bus.req0_ready || bus.req1_ready) ok = 0;
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_stable got=0 want=1"); end
    total++; if (s !== 16'h1010 || r !== 1'b0 || c !== 1'b0) begin
      bad++; $display("FAIL bp_first_resp got=%h/%b/%b want=1010/0/0", s, r, c);
    end
    bus.resp_ready = 1'b1;
    h_edge = cyc + 1;
    n = 0; a1_edge = -1;
    while (a1_edge < 0 && n < 20) begin
      @(negedge clk); n++;
      if (bus.req1_ready) a1_edge = cyc + 1;
    end
    total++; if (a1_edge !== h_edge + 1) begin
      bad++; $display("FAIL bp_next_accept got=%0d want=%0d", a1_edge, h_edge + 1);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
    exp_cnt = sat_inc(exp_cnt);
    total++; if (n >= 50 || bus.resp_sum !== 16'h0050 || bus.resp_id !== 1'b1) begin
      bad++; $display("FAIL bp_second_resp got=%h/%b want=0050/1", bus.resp_sum, bus.resp_id);
    end
    total++; if (gated_cnt !== 2'(exp_cnt)) begin
      bad++; $display("FAIL bp_cnt got=%0d want=%0d", gated_cnt, exp_cnt);
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_force_saturation();
    bit tmo, st; int ae, re; logic [15:0] s; logic c, r, g; logic [1:0] k;
    cg_force = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 0, tmo, ae, re, s, c, r, g, k, st);
    cg_force = 1'b0;
    total++; if (tmo || g !== 1'b1) begin bad++; $display("FAIL force_cg got=%b want=1", g); end
    total++; if (s !== 16'h0002 || k !== 2'(exp_cnt)) begin
      bad++; $display("FAIL force_resp got=%h cnt=%0d want=0002 cnt=%0d", s, k, exp_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      run_op(1'(i), 16'(i * 3), 16'h0005, 1'(i), 0, tmo, ae, re, s, c, r, g, k, st);
      exp_cnt = sat_inc(exp_cnt);
      total++; if (tmo || g !== 1'b0 || k !== 2'(exp_cnt)) begin
        bad++; $display("FAIL sat_step%0d got=cg%b cnt%0d want=cg0 cnt%0d", i, g, k, exp_cnt);
      end
    end
    total++; if (gated_cnt !== 2'd3) begin bad++; $display("FAIL sat_final got=%0d want=3", gated_cnt); end
  endtask

  task automatic test_round_robin();
    int acc_e[16];
    logic acc_id[16];
    logic [15:0] r_sum[16];
    logic r_cout[16];
    logic r_id[16];
    int na, nr;
    bit both;
    do_reset();
    na = 0; nr = 0; both = 0;
    bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0001; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
    bus.req1_a = 16'h8000; bus.req1_b = 16'h8000; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
      if (bus.req0_ready && bus.req1_ready) both = 1;
      if (na < 16 && bus.req0_valid && bus.req0_ready) begin acc_e[na] = cyc + 1; acc_id[na] = 1'b0; na++; end
      if (na < 16 && bus.req1_valid && bus.req1_ready) begin acc_e[na] = cyc + 1; acc_id[na] = 1'b1; na++; end
      if (nr < 16 && bus.resp_valid && bus.resp_ready) begin
        r_sum[nr] = bus.resp_sum; r_cout[nr] = bus.resp_cout; r_id[nr] = bus.resp_id; nr++;
      end
    end
    bus.resp_ready = 1'b0;
    total++; if (both) begin bad++; $display("FAIL rr_both_ready got=1 want=0"); end
    total++; if (na < 4) begin bad++; $display("FAIL rr_accepts got=%0d want>=4", na); end
    total++; if (nr !== na) begin bad++; $display("FAIL rr_resp_count got=%0d want=%0d", nr, na); end
    for (int k = 0; k < na && k < nr; k++) begin
      total++; if (acc_id[k] !== 1'(k % 2)) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", k, acc_id[k], k % 2); end
      if (k > 0) begin
        total++; if (acc_e[k] - acc_e[k-1] !== 4) begin
          bad++; $display("FAIL rr_spacing%0d got=%0d want=4", k, acc_e[k] - acc_e[k-1]);
        end
      end
      total++; if (r_id[k] !== acc_id[k] || r_sum[k] !== 16'h0000 || r_cout[k] !== 1'b1) begin
        bad++; $display("FAIL rr_resp%0d got=id%0d %h c%0d want=id%0d 0000 c1", k, r_id[k], r_sum[k], r_cout[k], acc_id[k]);
      end
    end
    total++; if (gated_cnt !== 2'd0) begin bad++; $display("FAIL rr_cnt got=%0d want=0", gated_cnt); end
  endtask

  task automatic test_random();
    bit tmo, st, gt; int ae, re, mode, stall; logic [15:0] s, a, b; logic c, r, g, cin, id; logic [1:0] k;
    logic [16:0] full;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      a = 16'($urandom); b = 16'($urandom);
      if (mode == 1) begin a = 16'($urandom_range(0, 127)); b = 16'($urandom_range(0, 127)); end
      if (mode == 2) begin a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255)); end
      cin = 1'($urandom_range(0, 1));
      id = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 2);
      cg_force = ($urandom_range(0, 7) == 0);
      full = ref_sum(a, b, cin);
      gt = ref_gated(a, b, cin, cg_force);
      run_op(id, a, b, cin, stall, tmo, ae, re, s, c, r, g, k, st);
      if (gt) exp_cnt = sat_inc(exp_cnt);
      total++; if (tmo || s !== full[15:0] || c !== full[16] || r !== id) begin
        bad++; $display("FAIL rand%0d_resp got=%h/%b/%b want=%h/%b/%b", i, s, c, r, full[15:0], full[16], id);
      end
      total++; if (g !== !gt) begin bad++; $display("FAIL rand%0d_cg got=%b want=%b", i, g, !gt); end
      total++; if (re !== ae + 2 || !st) begin
        bad++; $display("FAIL rand%0d_timing got=lat%0d stable%0d want=lat2 stable1", i, re - ae, st);
      end
      total++; if (k !== 2'(exp_cnt)) begin bad++; $display("FAIL rand%0d_cnt got=%0d want=%0d", i, k, exp_cnt); end
    end
    cg_force = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit tmo, st, seen; int n, ae, re; logic [15:0] s; logic c, r, g; logic [1:0] k;
    @(negedge clk);
    bus.req0_a = 16'hABCD; bus.req0_b = 16'h1111; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
    bus.resp_ready = 1'b1;
    n = 0;
    while (!bus.req0_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1 reset_b = 1'b0;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_cout, add_cin, add_cg} !== 7'b0 ||
                 bus.resp_sum !== 16'h0 || add_a !== 16'h0 || add_b !== 16'h0 || gated_cnt !== 2'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=a%h b%h sum%h v%b cg%b cnt%0d want=all 0",
                      add_a, add_b, bus.resp_sum, bus.resp_valid, add_cg, gated_cnt);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (bus.resp_valid) seen = 1; end
    reset_b = 1'b1;
    exp_cnt = 0;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) seen = 1; end
    bus.resp_ready = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL mid_reset_no_resp got=1 want=0"); end
    run_op(1'b0, 16'h0102, 16'h0304, 1'b0, 0, tmo, ae, re, s, c, r, g, k, st);
    total++; if (tmo || s !== 16'h0406 || c !== 1'b0 || r !== 1'b0 || k !== 2'd0) begin
      bad++; $display("FAIL mid_reset_after got=%h/%b/%b cnt%0d want=0406/0/0 cnt0", s, c, r, k);
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_full_carry();
    test_gated_stale();
    test_backpressure();
    test_force_saturation();
    test_round_robin();
    test_random();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
